// File: rtl/rect_fill_scheduler.sv
// Round-robin scheduler that lets several requesters take turns filling solid
// rectangles through the single pixel-write port of the VGA adapter.
module rect_fill_scheduler #(
    parameter int NREQ = 4,
    parameter int nX   = 10,
    parameter int nY   = 9,
    parameter int CW   = 9,
    parameter int XMAX = 640,
    parameter int YMAX = 480
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*nX-1:0]         req_x0,
    input  logic [NREQ*nY-1:0]         req_y0,
    input  logic [NREQ*nX-1:0]         req_w,
    input  logic [NREQ*nY-1:0]         req_h,
    input  logic [NREQ*CW-1:0]         req_color,
    output logic [NREQ-1:0]            ack,
    output logic                       busy,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic [nX-1:0]              vga_x,
    output logic [nY-1:0]              vga_y,
    output logic [CW-1:0]              vga_color,
    output logic                       vga_write
);

    localparam int IW = $clog2(NREQ);
    localparam logic [nX:0] XLIM = XMAX[nX:0];
    localparam logic [nY:0] YLIM = YMAX[nY:0];

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   ptr;
    logic [nX-1:0]   x0_r, w_r, col, col_nx;
    logic [nY-1:0]   y0_r, h_r, row, row_nx;
    logic [CW-1:0]   color_r;

    logic [IW-1:0]   pick;
    logic            any;
    logic [nX-1:0]   sel_x0, sel_w;
    logic [nY-1:0]   sel_y0, sel_h;
    logic [CW-1:0]   sel_color;
    logic            sel_empty, end_col, last;
    logic [nX:0]     px;
    logic [nY:0]     py;

    // First set request at or above ptr, wrapping; lower loop index wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NREQ]) begin
                pick = IW'((int'(ptr) + i) % NREQ);
                any  = 1'b1;
            end
        end
    end

    assign sel_x0    = req_x0[int'(pick)*nX +: nX];
    assign sel_y0    = req_y0[int'(pick)*nY +: nY];
    assign sel_w     = req_w[int'(pick)*nX +: nX];
    assign sel_h     = req_h[int'(pick)*nY +: nY];
    assign sel_color = req_color[int'(pick)*CW +: CW];
    assign sel_empty = (sel_w == '0) || (sel_h == '0);

    // Output registers always hold the pixel for the current counters, so the
    // next pixel is computed one step ahead from the advanced counters.
    assign end_col = (col == w_r - 1'b1);
    assign last    = end_col && (row == h_r - 1'b1);
    assign col_nx  = end_col ? '0 : col + 1'b1;
    assign row_nx  = end_col ? row + 1'b1 : row;
    assign px      = {1'b0, x0_r} + {1'b0, col_nx};
    assign py      = {1'b0, y0_r} + {1'b0, row_nx};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (any) state_nx = sel_empty ? DONE : DRAW;
            DRAW: if (last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ack = '0;
        if (state == DONE) ack[grant_id] = 1'b1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            x0_r      <= '0;
            y0_r      <= '0;
            w_r       <= '0;
            h_r       <= '0;
            color_r   <= '0;
            col       <= '0;
            row       <= '0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
            vga_write <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    vga_write <= 1'b0;
                    if (any) begin
                        grant_id  <= pick;
                        x0_r      <= sel_x0;
                        y0_r      <= sel_y0;
                        w_r       <= sel_w;
                        h_r       <= sel_h;
                        color_r   <= sel_color;
                        col       <= '0;
                        row       <= '0;
                        vga_x     <= sel_x0;
                        vga_y     <= sel_y0;
                        vga_color <= sel_color;
                        vga_write <= !sel_empty && ({1'b0, sel_x0} < XLIM)
                                     && ({1'b0, sel_y0} < YLIM);
                    end
                end
                DRAW: begin
                    if (last) begin
                        vga_write <= 1'b0;
                    end else begin
                        col       <= col_nx;
                        row       <= row_nx;
                        vga_x     <= px[nX-1:0];
                        vga_y     <= py[nY-1:0];
                        vga_color <= color_r;
                        vga_write <= (px < XLIM) && (py < YLIM);
                    end
                end
                DONE: begin
                    vga_write <= 1'b0;
                    ptr       <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                end
                default: vga_write <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_scheduler.sv
// Directed bench for rect_fill_scheduler: single job, round-robin, clipping,
// zero-size jobs, mid-job input changes and reset in the middle of a job.
module tb_rect_fill_scheduler;

    localparam int NREQ = 4;
    localparam int nX   = 10;
    localparam int nY   = 9;
    localparam int CW   = 9;

    logic                 clock;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*nX-1:0]   req_x0;
    logic [NREQ*nY-1:0]   req_y0;
    logic [NREQ*nX-1:0]   req_w;
    logic [NREQ*nY-1:0]   req_h;
    logic [NREQ*CW-1:0]   req_color;
    logic [NREQ-1:0]      ack;
    logic                 busy;
    logic [1:0]           grant_id;
    logic [nX-1:0]        vga_x;
    logic [nY-1:0]        vga_y;
    logic [CW-1:0]        vga_color;
    logic                 vga_write;

    int n_checks = 0;
    int n_fail   = 0;

    rect_fill_scheduler #(
        .NREQ(NREQ), .nX(nX), .nY(nY), .CW(CW), .XMAX(640), .YMAX(480)
    ) dut (
        .clock(clock), .reset(reset), .req(req),
        .req_x0(req_x0), .req_y0(req_y0), .req_w(req_w), .req_h(req_h),
        .req_color(req_color), .ack(ack), .busy(busy), .grant_id(grant_id),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_write(vga_write)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Global invariants, checked every cycle outside reset.
    always @(negedge clock) begin
        if (!reset) begin
            check("ack_onehot", 32'($onehot0(ack)), 32'd1);
            if (vga_write) check("write_implies_busy", 32'(busy), 32'd1);
        end
    end

    task automatic set_job(input int i, input int x0, input int y0, input int w,
                           input int h, input int c);
        req_x0[i*nX +: nX]    = nX'(x0);
        req_y0[i*nY +: nY]    = nY'(y0);
        req_w[i*nX +: nX]     = nX'(w);
        req_h[i*nY +: nY]     = nY'(h);
        req_color[i*CW +: CW] = CW'(c);
    endtask

    // Issues one job from requester i and checks every pixel cycle and the ack.
    task automatic run_single(input int i, input int x0, input int y0, input int w,
                              input int h, input int c);
        int ex, ey;
        bit ew;
        set_job(i, x0, y0, w, h, c);
        req[i] = 1'b1;
        tick();
        check("grant_id", 32'(grant_id), 32'(i));
        for (int n = 0; n < w * h; n++) begin
            ex = x0 + n % w;
            ey = y0 + n / w;
            ew = (ex < 640) && (ey < 480);
            check("busy_draw", 32'(busy), 32'd1);
            check("write", 32'(vga_write), 32'(ew));
            check("ack_draw", 32'(ack), 32'd0);
            if (ew) begin
                check("px_x", 32'(vga_x), 32'(ex));
                check("px_y", 32'(vga_y), 32'(ey));
                check("px_color", 32'(vga_color), 32'(c));
            end
            tick();
        end
        check("ack", 32'(ack), 32'(1 << i));
        check("busy_ack", 32'(busy), 32'd1);
        check("write_ack", 32'(vga_write), 32'd0);
        req[i] = 1'b0;
        tick();
        check("ack_after", 32'(ack), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic wait_ack(output logic [NREQ-1:0] a);
        int cnt;
        cnt = 0;
        while (ack == '0 && cnt < 60) begin
            tick();
            cnt++;
        end
        if (ack == '0) check("ack_timeout", 32'd0, 32'd1);
        a = ack;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] a;
        int exp_id;
        reset = 1'b1;
        req = '0; req_x0 = '0; req_y0 = '0; req_w = '0; req_h = '0; req_color = '0;
        tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_write", 32'(vga_write), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Single job: (10,20) 3x2 colour 0x1FF, ack on the 7th cycle after grant.
        run_single(1, 10, 20, 3, 2, 'h1FF);

        // Clipping at the bottom-right corner: only two visible pixels.
        run_single(0, 638, 479, 4, 2, 'h0F0);

        // Zero-size jobs ack immediately.
        run_single(2, 5, 5, 0, 5, 'h111);
        run_single(2, 5, 5, 5, 0, 'h111);

        // Round-robin: 0 then 2 after reset, then 3,0,1,2,... with all four.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_job(i, 10 * i, 7, 1, 1, i + 1);
        req = 4'b0101;
        wait_ack(a);
        check("rr_first", 32'(a), 32'b0001);
        req[0] = 1'b0;
        tick();
        wait_ack(a);
        check("rr_second", 32'(a), 32'b0100);
        req = 4'b1011;
        tick();
        req = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            exp_id = (3 + j) % NREQ;
            wait_ack(a);
            check("rr_order", 32'(a), 32'(1 << exp_id));
            check("rr_grant_id", 32'(grant_id), 32'(exp_id));
            req = req & ~a;
            tick();
            req = 4'b1111;
        end
        req = '0;
        tick();
        tick();

        // Mid-job changes: all 16 pixels from the latched 4x4 job at (100,50).
        set_job(2, 100, 50, 4, 4, 'h0AA);
        req[2] = 1'b1;
        tick();
        for (int n = 0; n < 16; n++) begin
            if (n == 3) begin
                req_color[2*CW +: CW] = 9'h155;
                req_x0[2*nX +: nX]    = 10'd300;
                req_w[2*nX +: nX]     = 10'd2;
            end
            if (n == 6) req[2] = 1'b0;
            check("mid_write", 32'(vga_write), 32'd1);
            check("mid_x", 32'(vga_x), 32'(100 + n % 4));
            check("mid_y", 32'(vga_y), 32'(50 + n / 4));
            check("mid_color", 32'(vga_color), 32'h0AA);
            tick();
        end
        check("mid_ack", 32'(ack), 32'b0100);
        tick();

        // Reset after five pixels of a 4x4 job aborts it with no ack.
        set_job(3, 0, 0, 4, 4, 'h007);
        set_job(1, 20, 30, 1, 1, 'h070);
        req[3] = 1'b1;
        tick();
        for (int n = 0; n < 5; n++) tick();
        check("pre_rst_write", 32'(vga_write), 32'd1);
        reset = 1'b1;
        #1;
        check("async_write", 32'(vga_write), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_ack", 32'(ack), 32'd0);
        req[1] = 1'b1;
        tick();
        check("rst_hold_ack", 32'(ack), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_grant", 32'(grant_id), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd1);
        wait_ack(a);
        check("post_rst_ack", 32'(a), 32'b0010);
        req = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
